// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 8-bit CPU bus, with a byte-serial loader that fills the store.
// Optional memory-mapped I/O register and input port when MEM_IO_EN is defined.
module cpu_mem_responder #(
    parameter int unsigned        ADDR_W   = 8,
    parameter int unsigned        DATA_W   = 8,
    parameter logic [ADDR_W-1:0]  IO_OUT_A = 8'hFF,
    parameter logic [ADDR_W-1:0]  IO_IN_A  = 8'hFE
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rden,
    input  logic              wren,
    output logic [DATA_W-1:0] data_out,
    input  logic              ld_start,
    input  logic [ADDR_W:0]   ld_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    output logic              ld_done,
`ifdef MEM_IO_EN
    output logic [DATA_W-1:0] io_out,
    input  logic [DATA_W-1:0] io_in,
`endif
    output logic              bus_busy
);

    localparam int unsigned     Depth    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DepthCnt = (ADDR_W + 1)'(Depth);

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     remain_q, remain_d;
    logic [DATA_W-1:0]   data_out_q, data_out_d;
    logic [DATA_W-1:0]   mem_q [Depth];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

`ifdef MEM_IO_EN
    logic [DATA_W-1:0]   io_out_q, io_out_d;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        remain_d   = remain_q;
        data_out_d = data_out_q;
        mem_we     = 1'b0;
        mem_waddr  = addr;
        mem_wdata  = data_in;
`ifdef MEM_IO_EN
        io_out_d   = io_out_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (ld_start && (ld_count != '0)) begin
                    state_d  = StLoad;
                    ptr_d    = '0;
                    remain_d = (ld_count > DepthCnt) ? DepthCnt : ld_count;
                end
                // A simultaneous read is dropped; the write wins.
                if (wren) begin
`ifdef MEM_IO_EN
                    if (addr == IO_OUT_A) begin
                        io_out_d = data_in;
                    end else begin
                        mem_we = 1'b1;
                    end
`else
                    mem_we = 1'b1;
`endif
                end else if (rden) begin
                    data_out_d = mem_q[addr];
`ifdef MEM_IO_EN
                    if (addr == IO_IN_A) begin
                        data_out_d = io_in;
                    end else if (addr == IO_OUT_A) begin
                        data_out_d = io_out_q;
                    end
`endif
                end
            end
            StLoad: begin
                if (ld_valid) begin
                    mem_we    = 1'b1;
                    mem_waddr = ptr_q;
                    mem_wdata = ld_data;
                    ptr_d     = ptr_q + 1'b1;
                    remain_d  = remain_q - 1'b1;
                    if (remain_q == (ADDR_W + 1)'(1)) begin
                        state_d = StDone;
                    end
                end
                if (rden) begin
                    data_out_d = '0;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (rden) begin
                    data_out_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        // A reset cycle must not commit a half-accepted loader or CPU write.
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            remain_q   <= '0;
            data_out_q <= '0;
`ifdef MEM_IO_EN
            io_out_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            remain_q   <= remain_d;
            data_out_q <= data_out_d;
`ifdef MEM_IO_EN
            io_out_q   <= io_out_d;
`endif
        end
    end

    // Store contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out = data_out_q;
    assign ld_ready = (state_q == StLoad);
    assign ld_done  = (state_q == StDone);
    assign bus_busy = (state_q != StIdle);
`ifdef MEM_IO_EN
    assign io_out   = io_out_q;
`endif

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: loader, stall, abort, wrap/clamp and CPU bus ordering.
// Covers the MEM_IO_EN register/port when that macro is defined.
module tb_cpu_mem_responder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] addr = '0;
    logic [7:0] data_in = '0;
    logic       rden = 1'b0;
    logic       wren = 1'b0;
    logic [7:0] data_out;
    logic       ld_start = 1'b0;
    logic [8:0] ld_count = '0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_ready;
    logic       ld_done;
    logic       bus_busy;
`ifdef MEM_IO_EN
    logic [7:0] io_out;
    logic [7:0] io_in = '0;
`endif

    int vectors = 0;
    int miscompares = 0;

    cpu_mem_responder dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .rden     (rden),
        .wren     (wren),
        .data_out (data_out),
        .ld_start (ld_start),
        .ld_count (ld_count),
        .ld_valid (ld_valid),
        .ld_data  (ld_data),
        .ld_ready (ld_ready),
        .ld_done  (ld_done),
`ifdef MEM_IO_EN
        .io_out   (io_out),
        .io_in    (io_in),
`endif
        .bus_busy (bus_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic cpu_read(input logic [7:0] a, input logic [7:0] exp, input string tag);
        rden = 1'b1;
        addr = a;
        tick();
        rden = 1'b0;
        chk8(tag, data_out, exp);
    endtask

    logic [7:0] img [4];
    logic       early_done;

    initial begin
        img[0] = 8'h28; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;

        // Reset state
        repeat (2) tick();
        chk8("rst_data_out", data_out, 8'h00);
        chk1("rst_ld_ready", ld_ready, 1'b0);
        chk1("rst_ld_done", ld_done, 1'b0);
        chk1("rst_bus_busy", bus_busy, 1'b0);
        rst = 1'b0;

        // Marker byte used later to prove a write during LOAD is dropped
        wren = 1'b1; addr = 8'h20; data_in = 8'h11;
        tick();
        wren = 1'b0;

        // Load 4 bytes with a 3-cycle stall after the first
        ld_start = 1'b1; ld_count = 9'd4;
        tick();
        ld_start = 1'b0;
        chk1("load_ready", ld_ready, 1'b1);
        chk1("load_busy", bus_busy, 1'b1);
        ld_valid = 1'b1; ld_data = img[0];
        tick();
        ld_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk1("stall_ready", ld_ready, 1'b1);
            chk1("stall_no_done", ld_done, 1'b0);
        end
        for (int i = 1; i < 4; i++) begin
            ld_valid = 1'b1; ld_data = img[i];
            tick();
        end
        ld_valid = 1'b0;
        chk1("done_pulse", ld_done, 1'b1);
        chk1("done_ready_low", ld_ready, 1'b0);
        chk1("done_busy", bus_busy, 1'b1);
        tick();
        chk1("done_one_cycle", ld_done, 1'b0);
        chk1("busy_released", bus_busy, 1'b0);
        for (int i = 0; i < 4; i++) cpu_read(8'(i), img[i], "load_readback");

        // CPU bus ordering
        cpu_read(8'h00, 8'h28, "pre_read");
        wren = 1'b1; addr = 8'h10; data_in = 8'hA5;
        tick();
        wren = 1'b0;
        chk8("write_hold", data_out, 8'h28);
        cpu_read(8'h10, 8'hA5, "raw_same_addr");
        rden = 1'b1; wren = 1'b1; addr = 8'h10; data_in = 8'h5A;
        tick();
        rden = 1'b0; wren = 1'b0;
        chk8("rw_read_dropped", data_out, 8'hA5);
        cpu_read(8'h10, 8'h5A, "rw_write_done");
        tick();
        chk8("idle_hold", data_out, 8'h5A);

        // Zero-count start is ignored
        ld_start = 1'b1; ld_count = 9'd0;
        tick();
        ld_start = 1'b0;
        chk1("count0_ignored", bus_busy, 1'b0);

        // Abort a 4-byte load after 2 bytes; CPU access during LOAD
        ld_start = 1'b1; ld_count = 9'd4;
        tick();
        ld_start = 1'b0;
        cpu_read(8'h00, 8'h00, "load_read_zero");
        wren = 1'b1; addr = 8'h20; data_in = 8'h99;
        tick();
        wren = 1'b0;
        ld_valid = 1'b1; ld_data = 8'hB0;
        tick();
        ld_data = 8'hB1;
        tick();
        ld_data = 8'hB2; rst = 1'b1;
        tick();
        rst = 1'b0; ld_valid = 1'b0;
        chk1("abort_ready", ld_ready, 1'b0);
        chk1("abort_busy", bus_busy, 1'b0);
        chk1("abort_no_done", ld_done, 1'b0);
        tick();
        chk1("abort_no_done_late", ld_done, 1'b0);
        cpu_read(8'h00, 8'hB0, "abort_byte0");
        cpu_read(8'h01, 8'hB1, "abort_byte1");
        cpu_read(8'h02, 8'h00, "abort_byte2_kept");
        cpu_read(8'h20, 8'h11, "load_write_dropped");

        // Oversized count clamps to 256
        ld_start = 1'b1; ld_count = 9'h1FF;
        tick();
        ld_start = 1'b0;
        early_done = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i) ^ 8'hC3;
            tick();
            if (i < 255) early_done = early_done | ld_done;
        end
        ld_valid = 1'b0;
        chk1("clamp_no_early_done", early_done, 1'b0);
        chk1("clamp_done", ld_done, 1'b1);
        tick();
        chk1("clamp_idle", bus_busy, 1'b0);
        cpu_read(8'h7F, 8'hBC, "clamp_byte7f");

        // Full 256-byte load, pointer wraps 255->0
        ld_start = 1'b1; ld_count = 9'h100;
        tick();
        ld_start = 1'b0;
        early_done = 1'b0;
        for (int i = 0; i < 256; i++) begin
            ld_valid = 1'b1; ld_data = 8'(i) + 8'h03;
            tick();
            if (i < 255) early_done = early_done | ld_done;
        end
        ld_valid = 1'b0;
        chk1("full_no_early_done", early_done, 1'b0);
        chk1("full_done", ld_done, 1'b1);
        tick();
        chk1("full_single_done", ld_done, 1'b0);
        cpu_read(8'h00, 8'h03, "full_byte00");
        cpu_read(8'h80, 8'h83, "full_byte80");
`ifndef MEM_IO_EN
        cpu_read(8'hFF, 8'h02, "full_byteff");
`else
        chk8("full_byteff", dut.mem_q[255], 8'h02);

        // Memory-mapped I/O
        wren = 1'b1; addr = 8'hFF; data_in = 8'h3C;
        tick();
        wren = 1'b0;
        chk8("io_out_written", io_out, 8'h3C);
        chk8("io_mem_ff_kept", dut.mem_q[255], 8'h02);
        io_in = 8'h77;
        cpu_read(8'hFE, 8'h77, "io_in_read");
        cpu_read(8'hFF, 8'h3C, "io_out_read");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
